// File: rtl/cnt60_run_ctrl.sv
// cnt60_run_ctrl: run/stop/alarm sequencer for a mod-60 up/down counter.
// It divides CLK into DIV-cycle ticks and turns each tick into a one-cycle
// ENABLE strobe with direction DEC (1 = up, 0 = down). It also decodes
// start/stop, direction and clear button pulses, and stops with ALARM
// raised when a down-count reaches 00. Every output comes straight from a flop.
module cnt60_run_ctrl #(
    parameter int DIV   = 100000000,
    parameter int DIV_W = 27
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_SS,
    input  logic       BTN_DIR,
    input  logic       BTN_CLR,
    input  logic [3:0] CNT10,
    input  logic [2:0] CNT6,
    output logic       ENABLE,
    output logic       DEC,
    output logic       CLR_N,
    output logic       RUNNING,
    output logic       ALARM
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE = DIV_W'(1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               dec_q, dec_d;
    logic               enable_q, enable_d;
    logic               clr_n_q, clr_n_d;
    logic               running_q, running_d;
    logic               alarm_q, alarm_d;

    logic               count_zero;
    logic               at_max;

    assign count_zero = (CNT10 == 4'd0) && (CNT6 == 3'd0);
    assign at_max     = (presc_q == PRESC_MAX);

    // Next-state logic. Buttons are prioritised CLR > SS > DIR. A tick in RUN
    // is evaluated only when no button is active. If DIR lands on a tick,
    // the prescaler holds at DIV-1 for one more cycle. The tick is then taken
    // with the new direction, so ENABLE and DEC always change together.
    always_comb begin
        state_d  = state_q;
        presc_d  = '0;
        dec_d    = dec_q;
        enable_d = 1'b0;
        clr_n_d  = 1'b1;
        unique case (state_q)
            ST_RUN: begin
                if (BTN_CLR) begin
                    clr_n_d = 1'b0;
                end else if (BTN_SS) begin
                    state_d = ST_STOP;
                end else if (BTN_DIR) begin
                    dec_d   = ~dec_q;
                    presc_d = at_max ? presc_q : presc_q + PRESC_ONE;
                end else if (at_max) begin
                    // Down-count at 00: raise the alarm instead of wrapping to 59
                    if (!dec_q && count_zero) begin
                        state_d = ST_ALARM;
                    end else begin
                        enable_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            ST_STOP: begin
                if (BTN_CLR) begin
                    clr_n_d = 1'b0;
                end else if (BTN_SS) begin
                    // Starting a down-count from 00 would alarm at once; ignore it
                    if (dec_q || !count_zero) begin
                        state_d = ST_RUN;
                    end
                end else if (BTN_DIR) begin
                    dec_d = ~dec_q;
                end
            end
            ST_ALARM: begin
                if (BTN_CLR) begin
                    clr_n_d = 1'b0;
                    state_d = ST_STOP;
                end else if (BTN_SS) begin
                    state_d = ST_STOP;
                end else if (BTN_DIR) begin
                    dec_d = ~dec_q;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    // State and output registers. Reset drops any pending tick and pulls CLR_N low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_STOP;
            presc_q   <= '0;
            dec_q     <= 1'b1;
            enable_q  <= 1'b0;
            clr_n_q   <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            dec_q     <= dec_d;
            enable_q  <= enable_d;
            clr_n_q   <= clr_n_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign ENABLE  = enable_q;
    assign DEC     = dec_q;
    assign CLR_N   = clr_n_q;
    assign RUNNING = running_q;
    assign ALARM   = alarm_q;

endmodule

// File: tb/tb_cnt60_run_ctrl.sv
// Bench for cnt60_run_ctrl with DIV=4. It contains an absolute-time model of
// the sequencer and a mod-60 counter that follows the expected strobes, plus
// directed scenarios with literal cycle-by-cycle expectations.
module tb_cnt60_run_ctrl;

    localparam int DIV = 4;

    logic clk;
    logic rst;
    logic btn_ss, btn_dir, btn_clr;
    logic [3:0] cnt10;
    logic [2:0] cnt6;
    logic enable, dec, clr_n, running, alarm;

    int checks = 0;
    int errors = 0;

    // Bench-side mod-60 counter, driven by the model's expected strobes
    int cnt = 0;
    logic load_req = 1'b0;
    int load_val = 0;

    // Model state
    localparam int S_STOP = 0, S_RUN = 1, S_ALARM = 2;
    int   m_st = S_STOP;
    logic m_dec = 1'b1, m_en = 1'b0, m_clrn = 1'b0;
    logic m_valid = 1'b0;
    int   cyc = 0;
    int   tick_at = 0;

    assign cnt10 = 4'(cnt % 10);
    assign cnt6  = 3'(cnt / 10);

    cnt60_run_ctrl #(.DIV(DIV), .DIV_W(3)) dut (
        .CLK(clk), .RESET(rst),
        .BTN_SS(btn_ss), .BTN_DIR(btn_dir), .BTN_CLR(btn_clr),
        .CNT10(cnt10), .CNT6(cnt6),
        .ENABLE(enable), .DEC(dec), .CLR_N(clr_n),
        .RUNNING(running), .ALARM(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a tick happens at the edge number tick_at. It is scheduled DIV
    // edges after the run starts, a clear or the previous tick, and moves one
    // edge later if a direction toggle lands on it.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_st = S_STOP; m_dec = 1'b1; m_en = 1'b0; m_clrn = 1'b0; m_valid = 1'b1;
        end else begin
            m_en = 1'b0;
            m_clrn = 1'b1;
            if (btn_clr) begin
                m_clrn = 1'b0;
                tick_at = cyc + DIV;
                if (m_st == S_ALARM) m_st = S_STOP;
            end else if (btn_ss) begin
                if (m_st != S_STOP) m_st = S_STOP;
                else if (m_dec || cnt != 0) begin
                    m_st = S_RUN;
                    tick_at = cyc + DIV;
                end
            end else if (btn_dir) begin
                m_dec = !m_dec;
                if (cyc == tick_at) tick_at = cyc + 1;
            end else if (m_st == S_RUN && cyc == tick_at) begin
                tick_at = cyc + DIV;
                if (!m_dec && cnt == 0) m_st = S_ALARM;
                else m_en = 1'b1;
            end
        end
    end

    // Compare all outputs every cycle, then advance the bench counter
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({enable, dec, clr_n, running, alarm} !==
                {m_en, m_dec, m_clrn, m_st == S_RUN, m_st == S_ALARM}) begin
                errors++;
                $display("FAIL model_cmp t=%0t {en,dec,clrn,run,alm} actual=%b expected=%b",
                         $time, {enable, dec, clr_n, running, alarm},
                         {m_en, m_dec, m_clrn, m_st == S_RUN, m_st == S_ALARM});
            end
        end
        if (load_req) cnt = load_val;
        else if (!m_clrn) cnt = 0;
        else if (m_en) cnt = m_dec ? (cnt + 1) % 60 : (cnt + 59) % 60;
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
        end
    endtask

    // One-cycle button pulse; returns at negedge+1 of the cycle after the sampling edge
    task automatic pulse(input logic ss, input logic dir, input logic clr);
        @(negedge clk); #1;
        btn_ss = ss; btn_dir = dir; btn_clr = clr;
        @(negedge clk); #1;
        btn_ss = 1'b0; btn_dir = 1'b0; btn_clr = 1'b0;
    endtask

    task automatic load(input int v);
        @(negedge clk); #1;
        load_val = v; load_req = 1'b1;
        @(negedge clk); #1;
        load_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_ss = 1'b0; btn_dir = 1'b0; btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        // Reset state
        chk("rst_enable", enable, 1'b0);
        chk("rst_dec", dec, 1'b1);
        chk("rst_clrn", clr_n, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_alarm", alarm, 1'b0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("clrn_release", clr_n, 1'b1);

        // 1: start counting up, ENABLE at t0+5 and t0+9
        pulse(1'b1, 1'b0, 1'b0);
        chk("t1_running", running, 1'b1);
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk); #1;
            chk("t1_enable", enable, (i == 5 || i == 9));
            chk("t1_dec", dec, 1'b1);
        end

        // 2: stop, switch to down, count 01 -> one ENABLE, then ALARM
        pulse(1'b1, 1'b0, 1'b0);
        chk("t2_stopped", running, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("t2_dec_down", dec, 1'b0);
        load(1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("t2_running", running, 1'b1);
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk); #1;
            chk("t2_enable", enable, (i == 5));
            chk("t2_alarm", alarm, (i >= 9));
        end
        chk("t2_run_off", running, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("t2_alarm_dir", dec, 1'b1);
        chk("t2_alarm_held", alarm, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("t2_alarm_clear", alarm, 1'b0);

        // 3: down-count from 00 cannot start
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("t3_running", running, 1'b0);
            chk("t3_enable", enable, 1'b0);
        end

        // 4: count down from 30, DIR on the tick at edge t0+8
        load(30);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        chk("t4_delay_en", enable, 1'b0);
        chk("t4_dec_flip", dec, 1'b1);
        for (int i = 10; i <= 14; i++) begin
            @(negedge clk); #1;
            chk("t4_enable", enable, (i == 10 || i == 14));
            chk("t4_dec", dec, 1'b1);
        end

        // 5: CLR with SS in RUN
        pulse(1'b1, 1'b0, 1'b1);
        chk("t5_clrn", clr_n, 1'b0);
        chk("t5_running", running, 1'b1);
        chk("t5_enable", enable, 1'b0);
        for (int i = 17; i <= 20; i++) begin
            @(negedge clk); #1;
            chk("t5_enable_after", enable, (i == 20));
            chk("t5_clrn_after", clr_n, 1'b1);
        end

        // 6: reset mid-RUN with prescaler at 2
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6_enable", enable, 1'b0);
        chk("t6_running", running, 1'b0);
        chk("t6_dec", dec, 1'b1);
        chk("t6_clrn", clr_n, 1'b0);
        chk("t6_alarm", alarm, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("t6_no_enable", enable, 1'b0);
        end

        // 7: SS beats DIR; up-count wraps 59 -> 00 without alarm
        load(59);
        pulse(1'b1, 1'b1, 1'b0);
        chk("t7_running", running, 1'b1);
        chk("t7_dec_kept", dec, 1'b1);
        for (int i = 2; i <= 9; i++) begin
            @(negedge clk); #1;
            chk("t7_enable", enable, (i == 5 || i == 9));
            chk("t7_alarm", alarm, 1'b0);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t7_clrn_stop", clr_n, 1'b0);
        chk("t7_stop", running, 1'b0);
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
